ext_req_initiator: RTL and testbench
====================================

# ext_req_initiator

Synthesizable initiator for the external-block request/ack protocol used by regblock external components: accepts one command at a time on a valid/ready port, issues a single-cycle `req` with address, data and bit-enables, then waits for the matching `rd_ack` or `wr_ack`. It returns the result on a valid/ready response port. It sits between a test or bridge master and any external responder, with an optional watchdog against responders that never acknowledge.

## Interface
- `WIDTH`, 32: data width in bits; multiple of 8.
- `ADDR_WIDTH`, 8: byte address width.
- `TIMEOUT`, 64: maximum wait cycles after `req` before an error response; ≥1; used only with `EXT_INIT_TIMEOUT_EN`.

- `clk` in 1: sole clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_is_wr` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: byte address, forwarded unchanged.
- `cmd_wr_data` in WIDTH: write data.
- `cmd_wr_biten` in WIDTH: per-bit write enables.
- `req` out 1: one-cycle request strobe.
- `req_is_wr`, `addr`, `wr_data`, `wr_biten` out 1/ADDR_WIDTH/WIDTH/WIDTH: request fields, registered, held from `req` until the next accept.
- `rd_ack` in 1, `rd_data` in WIDTH, `wr_ack` in 1: responder acknowledgements.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_is_wr` out 1: type of the completed command.
- `rsp_data` out WIDTH: captured `rd_data`; 0 for writes and errors.
- `rsp_err` out 1: completion by timeout.
- `stray_ack` out 1: one-cycle pulse on any ack that is not consumed.

## Operation
- States: IDLE, WAIT, RESP.
- Reset (`rst` low): state IDLE.
  - `req`, `req_is_wr`, `addr`, `wr_data`, `wr_biten`, `rsp_valid`, `rsp_is_wr`, `rsp_data`, `rsp_err`, `stray_ack` all 0; timeout counter 0.
  - `cmd_ready` = (state==IDLE), so it reads 1 in reset.
- IDLE: on `cmd_valid && cmd_ready`, register the command fields, set `req`=1 for the next cycle, go to WAIT.
- WAIT, first cycle (`req` high): acks are not consumed; any ack raises `stray_ack`.
- WAIT, later cycles:
  - Ack matching `req_is_wr` (`rd_ack` for a read, `wr_ack` for a write) is consumed.
  - Read: `rsp_data` <= `rd_data`. Write: `rsp_data` <= 0.
  - `rsp_err` <= 0, `rsp_valid` <= 1, go to RESP.
- Non-matching ack in WAIT, or any ack in IDLE or RESP: ignored, `stray_ack` pulses.
  - If `rd_ack` and `wr_ack` arrive together in WAIT, the matching one is consumed and `stray_ack` pulses for the other.
- RESP: hold all `rsp_*` stable until `rsp_ready`. On handshake, `rsp_valid` <= 0 and go to IDLE.
- Only one command is outstanding at a time; `cmd_ready` is 0 in WAIT and RESP.
- Reset mid-transaction abandons it. An ack arriving after reset release is stray.

## Timing
- Command accepted at edge N: `req` high in cycle N+1.
- Earliest consumable ack is in cycle N+2; `rsp_valid` rises at the next edge, so minimum accept-to-`rsp_valid` is 3 cycles.
- `rsp_ready` held high: `cmd_ready` returns 1 in the cycle after the response handshake; back-to-back throughput is one command per 4 cycles minimum.
- `stray_ack` is registered and asserts the cycle after the offending ack.
- `req` is never high for two consecutive cycles.

## Configuration
- `EXT_INIT_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entering WAIT and increments each WAIT cycle after the `req` cycle.
  - If it reaches TIMEOUT with no matching ack, the block goes to RESP with `rsp_err`=1 and `rsp_data`=0.
  - A matching ack in the same cycle the count reaches TIMEOUT wins: normal response, `rsp_err`=0.
  - A late ack after a timeout is stray.
- `EXT_INIT_TIMEOUT_EN` undefined: no counter; WAIT persists until a matching ack arrives; `rsp_err` is tied to 0.

## Test plan
- Write 0xDEADBEEF, biten 0xFFFF0000, addr 0x08; responder acks after 2 cycles -> one `req` pulse with those fields; response `rsp_is_wr`=1, `rsp_data`=0, `rsp_err`=0; responder memory word 2 = 0xDEAD0000.
- Read addr 0x08 with ack delays 0..3 -> `rsp_data`=0xDEAD0000 each time; a 0-delay ack gives `rsp_valid` exactly 3 cycles after accept.
- Hold `rsp_ready`=0 for 5 cycles after the response -> `rsp_*` stable, `cmd_ready`=0, no new `req`; release -> next command accepted the following cycle.
- Inject `wr_ack` while a read is outstanding, and any ack while IDLE -> `stray_ack` pulses once each; state is unchanged.
- With `EXT_INIT_TIMEOUT_EN`, TIMEOUT=4, responder silent -> `rsp_err`=1, `rsp_data`=0 after 4 wait cycles; a later ack raises `stray_ack`.
- Assert `rst` in WAIT, then release and send an ack -> all outputs 0 during reset; `stray_ack` pulses after release; the next command completes normally.

Source files
------------

// File: rtl/ext_req_initiator.sv
// Initiator for the external-block req/ack protocol: one command in flight, single-cycle req,
// registered response. Optional watchdog enabled by defining EXT_INIT_TIMEOUT_EN.
module ext_req_initiator #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    // Command port: a command transfers on a rising edge where cmd_valid && cmd_ready.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_is_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0]      cmd_wr_data,
    input  logic [WIDTH-1:0]      cmd_wr_biten,
    // Request to the responder
    output logic                  req,
    output logic                  req_is_wr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      wr_biten,
    input  logic                  rd_ack,
    input  logic [WIDTH-1:0]      rd_data,
    input  logic                  wr_ack,
    // Response port: rsp_* are held stable while rsp_valid && !rsp_ready.
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_is_wr,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  stray_ack,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;

    logic match_ack;
    logic other_ack;
    logic any_ack;

    if (TIMEOUT < 1 || (WIDTH % 8) != 0) begin : g_bad_param
        $error("ext_req_initiator: TIMEOUT must be >= 1 and WIDTH a multiple of 8");
    end

    always_comb begin
        any_ack   = rd_ack | wr_ack;
        match_ack = req_is_wr ? wr_ack : rd_ack;
        other_ack = req_is_wr ? rd_ack : wr_ack;
    end

    assign cmd_ready = (state == S_IDLE);
    assign state_dbg = state;

`ifdef EXT_INIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_next;

    assign wait_cnt_next = wait_cnt + CW'(1);
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            req       <= 1'b0;
            req_is_wr <= 1'b0;
            addr      <= '0;
            wr_data   <= '0;
            wr_biten  <= '0;
            rsp_valid <= 1'b0;
            rsp_is_wr <= 1'b0;
            rsp_data  <= '0;
            stray_ack <= 1'b0;
`ifdef EXT_INIT_TIMEOUT_EN
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            req       <= 1'b0;
            stray_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    stray_ack <= any_ack;
                    if (cmd_valid) begin
                        req       <= 1'b1;
                        req_is_wr <= cmd_is_wr;
                        addr      <= cmd_addr;
                        wr_data   <= cmd_wr_data;
                        wr_biten  <= cmd_wr_biten;
                        state     <= S_WAIT;
`ifdef EXT_INIT_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // The responder cannot legally answer in the req cycle itself.
                    if (req) begin
                        stray_ack <= any_ack;
                    end else begin
                        stray_ack <= other_ack;
                        if (match_ack) begin
                            rsp_valid <= 1'b1;
                            rsp_is_wr <= req_is_wr;
                            rsp_data  <= req_is_wr ? '0 : rd_data;
                            state     <= S_RESP;
`ifdef EXT_INIT_TIMEOUT_EN
                            rsp_err   <= 1'b0;
                        end else if (wait_cnt_next == TIMEOUT_CNT) begin
                            rsp_valid <= 1'b1;
                            rsp_is_wr <= req_is_wr;
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            wait_cnt  <= wait_cnt_next;
`endif
                        end
                    end
                end
                S_RESP: begin
                    stray_ack <= any_ack;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_req_initiator.sv
// Directed bench for ext_req_initiator: table of commands against a small memory responder,
// plus hand-written stray-ack, watchdog and reset sequences.
module tb_ext_req_initiator;
    localparam int W  = 32;
    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_is_wr;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_wr_data;
    logic [W-1:0]  cmd_wr_biten;
    logic          req;
    logic          req_is_wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  wr_biten;
    logic          rd_ack;
    logic [W-1:0]  rd_data;
    logic          wr_ack;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_is_wr;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic          stray_ack;
    logic [1:0]    state_dbg;

    ext_req_initiator #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_wr(cmd_is_wr),
        .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data), .cmd_wr_biten(cmd_wr_biten),
        .req(req), .req_is_wr(req_is_wr), .addr(addr), .wr_data(wr_data), .wr_biten(wr_biten),
        .rd_ack(rd_ack), .rd_data(rd_data), .wr_ack(wr_ack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_wr(rsp_is_wr),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .stray_ack(stray_ack), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] a;
        logic [W-1:0]  data;
        logic [W-1:0]  biten;
        int            delay;
        int            hold;
        logic [W-1:0]  exp_data;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int total;
    int bad;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mem [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_accept(input logic is_wr, input logic [AW-1:0] a,
                               input logic [W-1:0] data, input logic [W-1:0] biten);
        int n;
        n = 0;
        while (!cmd_ready && n < 16) begin
            step();
            n++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1);
        cmd_valid    = 1'b1;
        cmd_is_wr    = is_wr;
        cmd_addr     = a;
        cmd_wr_data  = data;
        cmd_wr_biten = biten;
        step();
        cmd_valid    = 1'b0;
        cmd_wr_data  = $urandom;
        cmd_wr_biten = $urandom;
        check("req_pulse", req, 1);
        check("req_is_wr", req_is_wr, is_wr);
        check("req_addr", addr, a);
        check("req_wr_data", wr_data, data);
        check("req_wr_biten", wr_biten, biten);
        check("cmd_ready_in_wait", cmd_ready, 0);
    endtask

    // Responder answers the outstanding request from its memory.
    task automatic give_ack();
        if (req_is_wr) begin
            mem[addr[7:2]] = (mem[addr[7:2]] & ~wr_biten) | (wr_data & wr_biten);
            wr_ack = 1'b1;
        end else begin
            rd_data = mem[addr[7:2]];
            rd_ack  = 1'b1;
        end
    endtask

    task automatic clear_ack();
        rd_ack  = 1'b0;
        wr_ack  = 1'b0;
        rd_data = 32'hBAD0_BAD0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("cmd_ready_after_hs", cmd_ready, 1);
    endtask

    task automatic do_cmd(input vec_t v);
        logic [W-1:0] exp_d;
        exp_q.push_back(v.exp_data);
        send_accept(v.is_wr, v.a, v.data, v.biten);
        step();
        check("req_single_cycle", req, 0);
        check("rsp_not_early", rsp_valid, 0);
        for (int i = 0; i < v.delay; i++) begin
            step();
            check("rsp_not_early", rsp_valid, 0);
            check("wait_state", state_dbg, 2'd1);
        end
        give_ack();
        step();
        clear_ack();
        exp_d = exp_q.pop_front();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_is_wr", rsp_is_wr, v.is_wr);
        check("rsp_data", rsp_data, exp_d);
        check("rsp_err", rsp_err, 0);
        check("no_stray", stray_ack, 0);
        for (int i = 0; i < v.hold; i++) begin
            step();
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, exp_d);
            check("hold_rsp_is_wr", rsp_is_wr, v.is_wr);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_no_req", req, 0);
        end
        handshake();
    endtask

    // ---------------- stimulus + checks ----------------
    initial begin
        total = 0;
        bad = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_is_wr = 1'b0;
        cmd_addr = '0;
        cmd_wr_data = '0;
        cmd_wr_biten = '0;
        rsp_ready = 1'b0;
        clear_ack();

        vecs[0] = '{1'b1, 8'h08, 32'hDEADBEEF, 32'hFFFF0000, 2, 0, 32'h0};
        vecs[1] = '{1'b0, 8'h08, 32'h0, 32'h0, 0, 0, 32'hDEAD0000};
        vecs[2] = '{1'b0, 8'h08, 32'h0, 32'h0, 1, 0, 32'hDEAD0000};
        vecs[3] = '{1'b0, 8'h08, 32'h0, 32'h0, 2, 0, 32'hDEAD0000};
        vecs[4] = '{1'b0, 8'h08, 32'h0, 32'h0, 3, 5, 32'hDEAD0000};
        vecs[5] = '{1'b1, 8'h0C, 32'h12345678, 32'h0000FFFF, 1, 5, 32'h0};
        vecs[6] = '{1'b0, 8'h0C, 32'h0, 32'h0, 0, 0, 32'h00005678};
        vecs[7] = '{1'b0, 8'h10, 32'h0, 32'h0, 1, 0, 32'h0};
        vecs[8] = '{1'b1, 8'h08, 32'h11223344, 32'h00FF00FF, 0, 0, 32'h0};
        vecs[9] = '{1'b0, 8'h08, 32'h0, 32'h0, 2, 0, 32'hDE220044};

        #12;
        check("rst_state", state_dbg, 2'd0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_req", req, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_stray", stray_ack, 0);
        step();
        rst = 1'b1;
        step();

        for (int i = 0; i < NV; i++) do_cmd(vecs[i]);
        check("mem_word2", mem[2], 32'hDE220044);

        // Any ack while idle
        rd_ack = 1'b1;
        step();
        clear_ack();
        check("idle_stray", stray_ack, 1);
        check("idle_state_kept", state_dbg, 2'd0);
        check("idle_no_rsp", rsp_valid, 0);
        step();
        check("idle_stray_one_pulse", stray_ack, 0);

        // Ack in the req cycle, then wrong-type ack, then both acks together
        send_accept(1'b0, 8'h0C, 32'h0, 32'h0);
        rd_ack = 1'b1;
        rd_data = 32'h0BAD_F00D;
        step();
        clear_ack();
        check("req_cycle_stray", stray_ack, 1);
        check("req_cycle_still_wait", state_dbg, 2'd1);
        check("req_cycle_no_rsp", rsp_valid, 0);
        wr_ack = 1'b1;
        step();
        clear_ack();
        check("wrong_ack_stray", stray_ack, 1);
        check("wrong_ack_still_wait", state_dbg, 2'd1);
        check("wrong_ack_no_rsp", rsp_valid, 0);
        wr_ack = 1'b1;
        rd_ack = 1'b1;
        rd_data = mem[3];
        step();
        clear_ack();
        check("both_ack_stray", stray_ack, 1);
        check("both_ack_rsp_valid", rsp_valid, 1);
        check("both_ack_rsp_data", rsp_data, 32'h00005678);
        check("both_ack_rsp_is_wr", rsp_is_wr, 0);
        handshake();

`ifdef EXT_INIT_TIMEOUT_EN
        // Silent responder: error after four post-req cycles, later ack is stray
        send_accept(1'b0, 8'h08, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_not_yet", rsp_valid, 0);
        end
        step();
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_data", rsp_data, 0);
        rd_ack = 1'b1;
        rd_data = 32'h1234_5678;
        step();
        clear_ack();
        check("to_late_stray", stray_ack, 1);
        check("to_data_kept", rsp_data, 0);
        handshake();
        // Ack in the same cycle the count reaches the limit wins
        send_accept(1'b0, 8'h08, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 3; i++) step();
        give_ack();
        step();
        clear_ack();
        check("to_race_valid", rsp_valid, 1);
        check("to_race_err", rsp_err, 0);
        check("to_race_data", rsp_data, 32'hDE220044);
        handshake();
`else
        // Without the watchdog a silent responder leaves the block waiting
        send_accept(1'b0, 8'h08, 32'h0, 32'h0);
        for (int i = 0; i < 12; i++) step();
        check("nowd_still_wait", state_dbg, 2'd1);
        check("nowd_no_rsp", rsp_valid, 0);
        give_ack();
        step();
        clear_ack();
        check("nowd_rsp_data", rsp_data, 32'hDE220044);
        check("nowd_rsp_err", rsp_err, 0);
        handshake();
`endif

        // Reset during WAIT
        send_accept(1'b1, 8'h14, 32'hA5A5A5A5, 32'hFFFFFFFF);
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_state", state_dbg, 2'd0);
        check("mid_rst_req_is_wr", req_is_wr, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_wr_biten", wr_biten, 0);
        check("mid_rst_rsp", {rsp_valid, rsp_is_wr, rsp_err, stray_ack, req}, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        step();
        rst = 1'b1;
        wr_ack = 1'b1;
        step();
        clear_ack();
        check("post_rst_stray", stray_ack, 1);
        check("post_rst_idle", state_dbg, 2'd0);
        check("post_rst_no_rsp", rsp_valid, 0);
        check("mem_word5_untouched", mem[5], 0);
        do_cmd(vecs[9]);

        // ---------------- report ----------------
        check("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

endmodule
